// File: rtl/slt_serial_32_bit.sv
`default_nettype none
// ============================================================================
// Module      : slt_serial_32_bit
// Description : Bit-serial set-less-than unit. Accepts an operand pair over a
//               valid/ready handshake, scans MSB-first one bit per cycle and
//               returns {zeros, lt} plus an equality flag over a second
//               valid/ready handshake. Signed (slt) or unsigned (sltu).
//               Optional macro SLT_EARLY_EXIT_EN: finish the scan in the cycle
//               the first differing bit is found (data-dependent latency).
// Revision    : 1.0 - initial release
// ============================================================================
module slt_serial_32_bit #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_unsigned,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             eq,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] C_MSB_IDX = IDX_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_unsigned;
    logic [IDX_W-1:0] r_idx;
    logic             r_decided;
    logic             r_lt;
    logic             r_lt_out;
    logic             r_eq;
    logic             r_out_valid;

    logic             w_bit_a;
    logic             w_bit_b;
    logic             w_decide_now;
    logic             w_lt_next;
    logic             w_finish;

    // Decision logic for the bit currently under examination
    always_comb begin
        w_bit_a      = r_a[r_idx];
        w_bit_b      = r_b[r_idx];
        w_decide_now = !r_decided && (w_bit_a != w_bit_b);
        w_lt_next    = r_lt;
        if (w_decide_now) begin
            // Differing sign bits in signed mode: the negative operand is smaller
            if ((r_idx == C_MSB_IDX) && !r_unsigned) begin
                w_lt_next = w_bit_a;
            end else begin
                w_lt_next = w_bit_b;
            end
        end
    end

`ifdef SLT_EARLY_EXIT_EN
    // Scan ends at bit 0 or as soon as the outcome is known
    assign w_finish = (r_idx == '0) || w_decide_now;
`else
    // Scan always covers every bit, giving constant latency
    assign w_finish = (r_idx == '0);
`endif

    // Control FSM, operand latch and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_unsigned  <= 1'b0;
            r_idx       <= '0;
            r_decided   <= 1'b0;
            r_lt        <= 1'b0;
            r_lt_out    <= 1'b0;
            r_eq        <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_unsigned <= is_unsigned;
                        r_idx      <= C_MSB_IDX;
                        r_decided  <= 1'b0;
                        r_lt       <= 1'b0;
                        r_state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    r_lt      <= w_lt_next;
                    r_decided <= r_decided | w_decide_now;
                    if (w_finish) begin
                        r_lt_out    <= w_lt_next;
                        r_eq        <= !(r_decided || w_decide_now);
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx - IDX_W'(1);
                    end
                end
                S_DONE: begin
                    // result/eq stay put after the handshake until the next completion
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE) && !reset;
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign eq        = r_eq;
    assign result    = {{(WIDTH-1){1'b0}}, r_lt_out};

endmodule
`default_nettype wire

// File: tb/tb_slt_serial_32_bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_slt_serial_32_bit
// Description : Self-checking bench for slt_serial_32_bit. A transaction-level
//               model predicts out_valid/busy/in_ready/result/eq every cycle;
//               directed vectors with literal expectations pin the model.
//               Honours SLT_EARLY_EXIT_EN for latency expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slt_serial_32_bit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         is_unsigned = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         eq;
    logic         busy;

    int total = 0;
    int bad   = 0;
    bit cmp_on = 1'b0;

    slt_serial_32_bit #(.WIDTH(W), .IDX_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .is_unsigned(is_unsigned),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .eq         (eq),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Latency in cycles from the accept edge to the first out_valid cycle
    function automatic int model_lat(input logic [W-1:0] x, input logic [W-1:0] y);
        int j;
        j = -1;
        for (int k = 0; k < W; k++) if (x[k] != y[k]) j = k;
`ifdef SLT_EARLY_EXIT_EN
        return (j < 0) ? W + 1 : W - j + 1;
`else
        return W + 1;
`endif
    endfunction

    function automatic logic model_lt(input logic [W-1:0] x, input logic [W-1:0] y, input logic u);
        if (u) return (x < y);
        return ($signed(x) < $signed(y));
    endfunction

    // Transaction-level model: busy / countdown / result holding
    int   cyc      = 0;
    bit   m_busy   = 1'b0;
    bit   m_ovalid = 1'b0;
    int   m_cnt    = 0;
    logic m_lt     = 1'b0;
    logic m_eqv    = 1'b0;
    logic m_res    = 1'b0;
    logic m_eq     = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy   = 1'b0;
            m_ovalid = 1'b0;
            m_res    = 1'b0;
            m_eq     = 1'b0;
        end else begin
            cyc++;
            if (m_ovalid) begin
                if (out_ready) begin
                    m_ovalid = 1'b0;
                    m_busy   = 1'b0;
                end
            end else if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_ovalid = 1'b1;
                    m_res    = m_lt;
                    m_eq     = m_eqv;
                end
            end else if (in_valid) begin
                m_busy = 1'b1;
                m_cnt  = model_lat(a, b) - 1;
                m_lt   = model_lt(a, b, is_unsigned);
                m_eqv  = (a == b);
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (cmp_on) begin
            check("out_valid", {63'b0, out_valid}, {63'b0, m_ovalid});
            check("busy",      {63'b0, busy},      {63'b0, m_busy});
            check("in_ready",  {63'b0, in_ready},  {63'b0, (!m_busy && !reset)});
            check("result",    {32'b0, result},    {63'b0, m_res});
            check("eq",        {63'b0, eq},        {63'b0, m_eq});
        end
    end

    task automatic junk_inputs();
        in_valid    = 1'($urandom_range(0, 1));
        a           = $urandom;
        b           = $urandom;
        is_unsigned = 1'($urandom_range(0, 1));
    endtask

    // One full transaction; called and returning on a falling edge
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tu,
                          input int hold, input bit lit, input logic lit_res,
                          input logic lit_eq, input int lit_lat_early);
        int n;
        int acc_cyc;
        int lat_obs;
        int lit_lat;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", {63'b0, in_ready}, 64'd1);
        a = ta; b = tbv; is_unsigned = tu; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        acc_cyc = cyc;
        n = 0;
        while (!out_valid && n < 100) begin
            junk_inputs();
            @(negedge clk);
            n++;
        end
        lat_obs = cyc - acc_cyc + 1;
        check("latency_model", lat_obs, model_lat(ta, tbv));
        if (lit) begin
`ifdef SLT_EARLY_EXIT_EN
            lit_lat = lit_lat_early;
`else
            lit_lat = W + 1;
`endif
            check("lit_result",  {32'b0, result}, {63'b0, lit_res});
            check("lit_eq",      {63'b0, eq},     {63'b0, lit_eq});
            check("lit_latency", lat_obs,         lit_lat);
        end
        repeat (hold) begin
            junk_inputs();
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("ready_after_take", {63'b0, in_ready}, 64'd1);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           sel;

        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        cmp_on = 1'b1;
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_busy",      {63'b0, busy},      64'd0);
        check("rst_result",    {32'b0, result},    64'd0);
        check("rst_eq",        {63'b0, eq},        64'd0);
        check("rst_in_ready",  {63'b0, in_ready},  64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed vectors with hand-computed expectations
        run_op(32'hFFFF_FFF9, 32'h0000_0006, 1'b0, 0, 1'b1, 1'b1, 1'b0, 2);
        run_op(32'hFFFF_FFF9, 32'h0000_0006, 1'b1, 0, 1'b1, 1'b0, 1'b0, 2);
        run_op(32'd128,       32'd64,        1'b0, 0, 1'b1, 1'b0, 1'b0, 26);
        run_op(32'd6,         32'd7,         1'b0, 1, 1'b1, 1'b1, 1'b0, 33);
        run_op(32'd8,         32'd48,        1'b0, 0, 1'b1, 1'b1, 1'b0, 28);
        run_op(32'd0,         32'd0,         1'b0, 0, 1'b1, 1'b0, 1'b1, 33);
        run_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 0, 1'b1, 1'b1, 1'b0, 2);
        run_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 0, 1'b1, 1'b0, 1'b0, 2);
        // Backpressure: result held for 10 cycles while other operands are offered
        run_op(32'hFFFF_FFF9, 32'h0000_0006, 1'b0, 10, 1'b1, 1'b1, 1'b0, 2);

        // Reset in the middle of a scan (idx 15), with a prior result of 1 held
        a = 32'd1; b = 32'd2; is_unsigned = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (16) @(negedge clk);
        check("pre_rst_busy", {63'b0, busy}, 64'd1);
        #2 reset = 1'b1;
        #1;
        check("midrst_out_valid", {63'b0, out_valid}, 64'd0);
        check("midrst_busy",      {63'b0, busy},      64'd0);
        check("midrst_result",    {32'b0, result},    64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_op(32'd1, 32'd2, 1'b0, 0, 1'b1, 1'b1, 1'b0, 32);

        // Randomized transactions with varied first-difference positions
        for (int i = 0; i < 40; i++) begin
            ra  = $urandom;
            sel = $urandom_range(0, 3);
            case (sel)
                0:       rb = $urandom;
                1:       rb = ra;
                2:       rb = ra ^ (32'h1 << $urandom_range(0, 31));
                default: rb = {ra[31:8], 8'($urandom)};
            endcase
            if ($urandom_range(0, 1) == 1) begin
                ra = rb;
                rb = ra ^ (32'h1 << $urandom_range(0, 31));
            end
            run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0, 1'b0, 1'b0, 0);
        end

        cmp_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
